// File: rtl/mux21_stim_chk_if.sv
// Stimulus/check bundle between the sequencer and its mux under test, plus run control.
// master = sequencer side, slave = controller/mux side.
interface mux21_stim_chk_if #(
  parameter int HOLD_W = 8,
  parameter int ERR_W  = 8
);
  logic              start;
  logic [HOLD_W-1:0] hold;
  logic [3:0]        loops;
  logic              a;
  logic              b;
  logic              s;
  logic              y;
  logic              busy;
  logic              done;
  logic [ERR_W-1:0]  err_cnt;
  logic              pass;

  modport master (
    input  start, hold, loops, y,
    output a, b, s, busy, done, err_cnt, pass
  );

  modport slave (
    output start, hold, loops, y,
    input  a, b, s, busy, done, err_cnt, pass
  );
endinterface

// File: rtl/mux21_stim_chk.sv
// On-chip 2:1 mux stimulus sequencer and checker: sweeps all 8 {a,b,s} vectors, samples y at the end of each hold window.
// Vector 0 appears one cycle after start is accepted; no backpressure, start is only sampled in IDLE.
module mux21_stim_chk #(
  parameter int HOLD_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux21_stim_chk_if.master     bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]        loops_q, loops_d;
  logic [3:0]        loop_cnt_q, loop_cnt_d;
  logic [2:0]        v_q, v_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              pass_q, pass_d;

  logic sample;
  logic last;
  logic exp_y;

  assign sample = (state_q == ST_RUN) && (hold_cnt_q == hold_q);
  assign last   = sample && (v_q == 3'd7) && (loop_cnt_q == loops_q - 4'd1);
  assign exp_y  = v_q[0] ? v_q[1] : v_q[2];

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    loops_d    = loops_q;
    loop_cnt_d = loop_cnt_q;
    v_d        = v_q;
    err_d      = err_q;
    pass_d     = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          hold_d     = bus.hold;
          loops_d    = (bus.loops == 4'd0) ? 4'd1 : bus.loops;
          err_d      = '0;
          pass_d     = 1'b0;
          v_d        = 3'd0;
          hold_cnt_d = '0;
          loop_cnt_d = 4'd0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (sample) begin
          if ((bus.y != exp_y) && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
          end
          hold_cnt_d = '0;
          // v wraps to 0 on the final compare, so a/b/s return to 0 in DONE
          v_d = v_q + 3'd1;
          if (v_q == 3'd7) begin
            loop_cnt_d = loop_cnt_q + 4'd1;
          end
          if (last) begin
            state_d = ST_DONE;
            pass_d  = (err_d == '0);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      loops_q    <= 4'd0;
      loop_cnt_q <= 4'd0;
      v_q        <= 3'd0;
      err_q      <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      loops_q    <= loops_d;
      loop_cnt_q <= loop_cnt_d;
      v_q        <= v_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.s       = v_q[0];
  assign bus.b       = v_q[1];
  assign bus.a       = v_q[2];
  assign bus.busy    = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.err_cnt = err_q;
  assign bus.pass    = pass_q;
endmodule

// File: tb/tb_mux21_stim_chk.sv
// Randomized bench for mux21_stim_chk: a behavioural mux (optionally faulty) closes the loop, a sweep-level model predicts vectors and error counts.
module tb_mux21_stim_chk;
  localparam int HOLD_W  = 8;
  localparam int ERR_W   = 4;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux21_stim_chk_if #(.HOLD_W(HOLD_W), .ERR_W(ERR_W)) bus ();

  mux21_stim_chk #(.HOLD_W(HOLD_W), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // mux model: 0 good, 1 stuck-at-0, 2 inverted, 3 inverted only on vector fault_v
  int         mode;
  logic [2:0] fault_v;
  logic       good_y;
  always_comb begin
    good_y = bus.s ? bus.b : bus.a;
    case (mode)
      1:       bus.y = 1'b0;
      2:       bus.y = ~good_y;
      3:       bus.y = ({bus.a, bus.b, bus.s} == fault_v) ? ~good_y : good_y;
      default: bus.y = good_y;
    endcase
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sweep_errs(input int m, input int fv);
    int n = 0;
    for (int v = 0; v < 8; v++) begin
      int s_v, b_v, a_v, good;
      bit bad;
      s_v  = v % 2;
      b_v  = (v / 2) % 2;
      a_v  = v / 4;
      good = (s_v == 1) ? b_v : a_v;
      case (m)
        1:       bad = (good == 1);
        2:       bad = 1'b1;
        3:       bad = (v == fv);
        default: bad = 1'b0;
      endcase
      if (bad) n++;
    end
    return n;
  endfunction

  // One complete run from IDLE; noisy toggles start/hold/loops during RUN, keep_start leaves start high afterwards.
  task automatic run(input int h, input int l, input int m, input int fv, input bit noisy, input bit keep_start);
    int le, len, exp_err;
    le  = (l == 0) ? 1 : l;
    len = 8 * (h + 1) * le;
    mode      = m;
    fault_v   = fv[2:0];
    bus.hold  = h[HOLD_W-1:0];
    bus.loops = l[3:0];
    bus.start = 1'b1;
    tick();
    bus.start = keep_start;
    for (int k = 0; k < len; k++) begin
      chk("busy_run", bus.busy, 1);
      chk("vec", {bus.a, bus.b, bus.s}, (k / (h + 1)) % 8);
      chk("done_run", bus.done, 0);
      if (noisy) begin
        bus.start = keep_start | ($urandom_range(0, 3) == 0);
        bus.hold  = HOLD_W'($urandom);
        bus.loops = 4'($urandom);
      end
      tick();
    end
    exp_err = le * sweep_errs(m, fv);
    if (exp_err > ERR_MAX) exp_err = ERR_MAX;
    chk("done", bus.done, 1);
    chk("busy_done", bus.busy, 0);
    chk("vec_done", {bus.a, bus.b, bus.s}, 0);
    chk("err", bus.err_cnt, exp_err);
    chk("pass", bus.pass, (exp_err == 0) ? 1 : 0);
    bus.start = keep_start;
    tick();
    chk("done_clr", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
    chk("err_hold", bus.err_cnt, exp_err);
    chk("pass_hold", bus.pass, (exp_err == 0) ? 1 : 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.hold  = '0;
    bus.loops = 4'd0;
    mode      = 0;
    fault_v   = 3'd0;
    #12;
    chk("rst_vec", {bus.a, bus.b, bus.s}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err_cnt, 0);
    chk("rst_pass", bus.pass, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", bus.busy, 0);

    run(0, 1, 0, 0, 1'b0, 1'b0);
    run(3, 2, 0, 0, 1'b0, 1'b0);
    run(1, 1, 1, 0, 1'b0, 1'b0);
    run(0, 15, 2, 0, 1'b0, 1'b0);
    run(0, 0, 0, 0, 1'b1, 1'b0);
    run(1, 1, 3, 5, 1'b0, 1'b1);
    run(2, 1, 0, 0, 1'b0, 1'b0);

    repeat (20) begin
      run($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
          $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'b0);
    end

    // reset in the middle of a stuck-at-0 run, after two mismatches have been counted
    mode      = 1;
    bus.hold  = '0;
    bus.loops = 4'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_vec", {bus.a, bus.b, bus.s}, 5);
    chk("pre_rst_err", bus.err_cnt, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vec", {bus.a, bus.b, bus.s}, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_err", bus.err_cnt, 0);
    chk("mid_rst_pass", bus.pass, 0);
    chk("mid_rst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_busy", bus.busy, 0);
    end
    run(0, 1, 0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
